// File: rtl/aibcr3_dcc_cal_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aibcr3_dcc_cal_ctrl
//  Description : DCC/DLL delay calibration sequencer. Runs an MSB-first
//                successive-approximation search over the 11-bit delay code,
//                one launch/measure/sample trial per bit, then holds the
//                locked code and optionally applies periodic +/-1 tracking.
//  Revision    : 1.0  initial release
// ============================================================================
module aibcr3_dcc_cal_ctrl #(
   parameter int SETTLE_CYC   = 8,    // code change -> launch pulse (1..255)
   parameter int MEAS_CYC     = 4,    // launch pulse -> measure pulse (1..255)
   parameter int RESULT_CYC   = 4,    // measure pulse -> t_up/t_down sample (1..255)
   parameter int TRACK_PERIOD = 256   // LOCK cycles between tracking trials (2..511)
) (
   input  logic        clk_dcd,
   input  logic        nrst,
   input  logic        cal_start,
   input  logic        cont_en,
   input  logic        t_up,
   input  logic        t_down,
   output logic        launch,
   output logic        measure,
   output logic [2:0]  i_gray,
   output logic [7:0]  f_gray,
   output logic [10:0] code_bin,
   output logic        cal_busy,
   output logic        dll_lock,
   output logic        dcc_done
);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_trial = 2'd1;
   localparam logic [1:0] c_lock  = 2'd2;
   localparam logic [1:0] c_track = 2'd3;

   // Trial-relative cycle positions; cycle 0 is the first cycle a code is driven
   localparam logic [9:0] c_launch_at = 10'(SETTLE_CYC);
   localparam logic [9:0] c_meas_at   = 10'(SETTLE_CYC + MEAS_CYC);
   localparam logic [9:0] c_sample_at = 10'(SETTLE_CYC + MEAS_CYC + RESULT_CYC);
   localparam logic [8:0] c_period_last = 9'(TRACK_PERIOD - 1);

   localparam logic [10:0] c_code_first = 11'h400;
   localparam logic [10:0] c_code_max   = 11'h7FF;
   localparam logic [10:0] c_code_min   = 11'h000;

   logic [1:0]  r_state;
   logic [9:0]  r_tcnt;      // cycle position within the current trial
   logic [8:0]  r_pcnt;      // LOCK-state tracking period counter
   logic [3:0]  r_bit;       // SAR bit under test
   logic [10:0] r_code;
   logic [10:0] r_gray;
   logic        r_lock;
   logic        r_done;

   logic [1:0]  w_state_nxt;
   logic [9:0]  w_tcnt_nxt;
   logic [8:0]  w_pcnt_nxt;
   logic [3:0]  w_bit_nxt;
   logic [10:0] w_code_nxt;
   logic        w_lock_nxt;
   logic        w_done_nxt;

   logic        w_in_trial;
   logic        w_sample;
   logic        w_keep;
   logic        w_dn;
   logic [3:0]  w_bit_m1;

   assign w_in_trial = (r_state == c_trial) || (r_state == c_track);
   assign w_sample   = (r_tcnt == c_sample_at);
   assign w_keep     = t_up & ~t_down;
   assign w_dn       = t_down & ~t_up;
   assign w_bit_m1   = r_bit - 4'd1;

   // Next-state, SAR and tracking decisions
   always_comb begin
      w_state_nxt = r_state;
      w_tcnt_nxt  = r_tcnt;
      w_pcnt_nxt  = r_pcnt;
      w_bit_nxt   = r_bit;
      w_code_nxt  = r_code;
      w_lock_nxt  = r_lock;
      w_done_nxt  = r_done;
      case (r_state)
         c_idle: begin
            if (cal_start) begin
               w_state_nxt = c_trial;
               w_code_nxt  = c_code_first;
               w_bit_nxt   = 4'd10;
               w_tcnt_nxt  = 10'd0;
               w_lock_nxt  = 1'b0;
            end
         end
         c_trial: begin
            if (w_sample) begin
               w_code_nxt[r_bit] = w_keep;
               w_tcnt_nxt        = 10'd0;
               if (r_bit != 4'd0) begin
                  // Next trial starts immediately with the next lower bit set
                  w_code_nxt[w_bit_m1] = 1'b1;
                  w_bit_nxt            = w_bit_m1;
               end else begin
                  w_state_nxt = c_lock;
                  w_lock_nxt  = 1'b1;
                  w_done_nxt  = 1'b1;
                  w_pcnt_nxt  = 9'd0;
               end
            end else begin
               w_tcnt_nxt = r_tcnt + 10'd1;
            end
         end
         c_lock: begin
            // A restart request wins over a due tracking trial
            if (cal_start) begin
               w_state_nxt = c_trial;
               w_code_nxt  = c_code_first;
               w_bit_nxt   = 4'd10;
               w_tcnt_nxt  = 10'd0;
               w_lock_nxt  = 1'b0;
               w_pcnt_nxt  = 9'd0;
            end else if (cont_en) begin
               if (r_pcnt == c_period_last) begin
                  w_state_nxt = c_track;
                  w_tcnt_nxt  = 10'd0;
                  w_pcnt_nxt  = 9'd0;
               end else begin
                  w_pcnt_nxt = r_pcnt + 9'd1;
               end
            end else begin
               w_pcnt_nxt = 9'd0;
            end
         end
         c_track: begin
            if (w_sample) begin
               if (w_keep && (r_code != c_code_max)) begin
                  w_code_nxt = r_code + 11'd1;
               end else if (w_dn && (r_code != c_code_min)) begin
                  w_code_nxt = r_code - 11'd1;
               end
               w_state_nxt = c_lock;
               w_tcnt_nxt  = 10'd0;
               w_pcnt_nxt  = 9'd0;
            end else begin
               w_tcnt_nxt = r_tcnt + 10'd1;
            end
         end
         default: begin
            w_state_nxt = c_idle;
         end
      endcase
   end

   // State registers; gray is computed from the next code so it moves with code_bin
   always_ff @(posedge clk_dcd) begin
      if (!nrst) begin
         r_state <= c_idle;
         r_tcnt  <= 10'd0;
         r_pcnt  <= 9'd0;
         r_bit   <= 4'd0;
         r_code  <= 11'd0;
         r_gray  <= 11'd0;
         r_lock  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tcnt  <= w_tcnt_nxt;
         r_pcnt  <= w_pcnt_nxt;
         r_bit   <= w_bit_nxt;
         r_code  <= w_code_nxt;
         r_gray  <= w_code_nxt ^ (w_code_nxt >> 1);
         r_lock  <= w_lock_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign launch   = w_in_trial && (r_tcnt == c_launch_at);
   assign measure  = w_in_trial && (r_tcnt == c_meas_at);
   assign cal_busy = w_in_trial;
   assign code_bin = r_code;
   assign i_gray   = r_gray[2:0];
   assign f_gray   = r_gray[10:3];
   assign dll_lock = r_lock;
   assign dcc_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_aibcr3_dcc_cal_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aibcr3_dcc_cal_ctrl
//  Description : Directed self-checking bench for aibcr3_dcc_cal_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aibcr3_dcc_cal_ctrl;

   logic        clk_dcd;
   logic        nrst;
   logic        cal_start;
   logic        cont_en;
   logic        t_up;
   logic        t_down;
   logic        launch;
   logic        measure;
   logic [2:0]  i_gray;
   logic [7:0]  f_gray;
   logic [10:0] code_bin;
   logic        cal_busy;
   logic        dll_lock;
   logic        dcc_done;

   int n_checks;
   int n_fail;
   int cyc;
   int mode;          // phase-detector model: 0 threshold, 1 up, 2 down, 3 both
   int launch_cnt;
   int meas_cnt;
   int bad_cnt;
   int launch_hist [64];
   int meas_hist   [64];

   aibcr3_dcc_cal_ctrl dut (
      .clk_dcd   (clk_dcd),
      .nrst      (nrst),
      .cal_start (cal_start),
      .cont_en   (cont_en),
      .t_up      (t_up),
      .t_down    (t_down),
      .launch    (launch),
      .measure   (measure),
      .i_gray    (i_gray),
      .f_gray    (f_gray),
      .code_bin  (code_bin),
      .cal_busy  (cal_busy),
      .dll_lock  (dll_lock),
      .dcc_done  (dcc_done)
   );

   // Clock
   initial clk_dcd = 1'b0;
   always #5 clk_dcd = ~clk_dcd;

   // Rising-edge counter
   initial cyc = 0;
   always @(posedge clk_dcd) cyc <= cyc + 1;

   // Phase-detector model
   always_comb begin
      t_up   = 1'b0;
      t_down = 1'b0;
      case (mode)
         0: begin
            t_up   = (code_bin < 11'h2A5);
            t_down = !(code_bin < 11'h2A5);
         end
         1: t_up = 1'b1;
         2: t_down = 1'b1;
         default: begin
            t_up   = 1'b1;
            t_down = 1'b1;
         end
      endcase
   end

   // Pulse monitor, sampled on the falling edge
   initial begin
      launch_cnt = 0;
      meas_cnt   = 0;
      bad_cnt    = 0;
   end
   always @(negedge clk_dcd) begin
      if (launch) begin
         launch_hist[launch_cnt % 64] = cyc;
         launch_cnt = launch_cnt + 1;
      end
      if (measure) begin
         meas_hist[meas_cnt % 64] = cyc;
         meas_cnt = meas_cnt + 1;
      end
      if ((launch && measure) || ((launch || measure) && !cal_busy))
         bad_cnt = bad_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Raise cal_start for hold cycles; e0 is the edge just before it is driven
   task automatic start_cal(input int hold, output int e0);
      @(negedge clk_dcd);
      cal_start = 1'b1;
      e0 = cyc;
      repeat (hold) @(negedge clk_dcd);
      cal_start = 1'b0;
   endtask

   task automatic wait_lock(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_dcd);
         if (dll_lock) begin
            at = cyc;
            break;
         end
      end
   endtask

   // One tracking trial: wait for its launch, then for its end
   task automatic track_trial(input string tag, output int lcyc);
      int seen;
      lcyc = -1;
      for (int i = 0; i < 700; i++) begin
         @(negedge clk_dcd);
         if (launch) begin
            lcyc = cyc;
            break;
         end
      end
      check({tag, "_launch_seen"}, (lcyc >= 0), 1);
      check({tag, "_lock_busy"}, {dll_lock, cal_busy}, 2'b11);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_dcd);
         if (!cal_busy) begin
            seen = 1;
            break;
         end
      end
      check({tag, "_end_seen"}, seen, 1);
   endtask

   int e0, at, lc0, mc0, l1, l2, nl;

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      mode      = 0;
      nrst      = 1'b0;
      cal_start = 1'b0;
      cont_en   = 1'b0;

      // Reset and idle
      repeat (3) @(negedge clk_dcd);
      check("rst_outputs", {launch, measure, i_gray, f_gray, code_bin, cal_busy, dll_lock, dcc_done}, 0);
      nrst = 1'b1;
      lc0 = launch_cnt;
      mc0 = meas_cnt;
      repeat (50) @(negedge clk_dcd);
      check("idle_pulses", (launch_cnt - lc0) + (meas_cnt - mc0), 0);
      check("idle_outputs", {launch, measure, i_gray, f_gray, code_bin, cal_busy, dll_lock, dcc_done}, 0);

      // SAR search against threshold 0x2A5
      lc0 = launch_cnt;
      mc0 = meas_cnt;
      start_cal(1, e0);
      check("sar_start_busy", {cal_busy, dll_lock, code_bin}, {2'b10, 11'h400});
      wait_lock(400, at);
      check("sar_lock_time", at, e0 + 188);
      check("sar_code", code_bin, 11'h2A4);
      check("sar_gray", {f_gray, i_gray}, {8'h7E, 3'h6});
      check("sar_done_busy", {dcc_done, cal_busy}, 2'b10);
      check("sar_n_launch", launch_cnt - lc0, 11);
      check("sar_n_measure", meas_cnt - mc0, 11);
      check("sar_first_launch", launch_hist[lc0 % 64], e0 + 9);
      check("sar_last_launch", launch_hist[(lc0 + 10) % 64], e0 + 179);
      check("sar_first_measure", meas_hist[mc0 % 64], e0 + 13);

      // All-down search, restarted from LOCK
      mode = 2;
      start_cal(1, e0);
      check("restart_state", {dll_lock, dcc_done, cal_busy, code_bin}, {3'b011, 11'h400});
      check("restart_gray", {f_gray, i_gray}, {8'hC0, 3'h0});
      wait_lock(400, at);
      check("down_lock_time", at, e0 + 188);
      check("down_code", {code_bin, f_gray, i_gray}, 0);

      // All-up search with cal_start held high through the trials
      mode = 1;
      lc0 = launch_cnt;
      start_cal(40, e0);
      wait_lock(400, at);
      check("up_lock_time", at, e0 + 188);
      check("up_n_launch", launch_cnt - lc0, 11);
      check("up_code", code_bin, 11'h7FF);
      check("up_gray", {f_gray, i_gray}, {8'h80, 3'h0});

      // Tracking with saturation
      cont_en = 1'b1;
      track_trial("trk1", l1);
      check("trk1_code", code_bin, 11'h7FF);
      track_trial("trk2", l2);
      check("trk2_code", code_bin, 11'h7FF);
      check("trk_period", l2 - l1, 273);
      mode = 2;
      track_trial("trk3", l1);
      check("trk3_code", {code_bin, f_gray, i_gray}, {11'h7FE, 8'h80, 3'h1});
      track_trial("trk4", l1);
      check("trk4_code", {code_bin, f_gray, i_gray}, {11'h7FD, 8'h80, 3'h3});
      mode = 3;
      track_trial("trk5", l1);
      check("trk5_code", code_bin, 11'h7FD);
      check("trk_lock", dll_lock, 1'b1);
      cont_en = 1'b0;

      // Reset in the cycle of the fifth launch pulse
      mode = 0;
      start_cal(1, e0);
      nl = 0;
      for (int i = 0; i < 200 && nl < 5; i++) begin
         @(negedge clk_dcd);
         if (launch) nl = nl + 1;
      end
      check("midrst_reached", nl, 5);
      nrst = 1'b0;
      @(negedge clk_dcd);
      check("midrst_outputs", {launch, measure, i_gray, f_gray, code_bin, cal_busy, dll_lock, dcc_done}, 0);
      nrst = 1'b1;
      start_cal(1, e0);
      wait_lock(400, at);
      check("rerun_lock_time", at, e0 + 188);
      check("rerun_result", {code_bin, f_gray, i_gray, dcc_done}, {11'h2A4, 8'h7E, 3'h6, 1'b1});

      check("pulse_rules", bad_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
